// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit
// Decode-stage hazard unit for the pipelined MIPS core. A per-register
// countdown scoreboard is loaded when an instruction issues from D to E and
// is used to stall D on RAW, WAW and long-unit structural hazards.
// Operand forwarding muxes live elsewhere; this block only produces the
// F/D/E enables and flushes.
//
// Handshake: valid_d marks a real instruction in D. The instruction issues
// (moves to E) in a cycle where valid_d=1 and stall_d=0; only then is its
// destination recorded or the long unit claimed. While stall_d=1 the
// upstream stages hold (stall_f, stall_d) and a bubble enters E (flush_e).
//
// Counter meaning for register r:
//   cnt = 0 : value is architecturally visible (RF or M-stage bus for D branches)
//   cnt = 1 : result is forwardable to an E-stage consumer next cycle
//   cnt > 1 : any consumer must wait
module scoreboard_hazard_unit #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 8,
  parameter int LW      = $clog2(MAX_LAT + 1),
  parameter int CW      = $clog2(MAX_LAT + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_d,
  input  logic [AW-1:0]    rs_d,
  input  logic [AW-1:0]    rt_d,
  input  logic             use_rs_d,
  input  logic             use_rt_d,
  input  logic             branch_d,
  input  logic [AW-1:0]    rd_d,
  input  logic             we_d,
  input  logic [LW-1:0]    lat_d,
  input  logic             long_d,
  input  logic             pc_src_d,
  input  logic             jump_d,
  input  logic             clear,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [NREGS-1:0] pend_mask
);

  // Scoreboard state: entry 0 exists only so indexing by rs/rt/rd needs no
  // special casing; it is forced to zero on every update.
  logic [CW-1:0] cnt [NREGS];
  logic [LW-1:0] ubusy;

  // Decode-side derived values
  logic [LW-1:0] lat_eff;
  logic [CW-1:0] lat_ld;
  logic [CW-1:0] cnt_rs;
  logic [CW-1:0] cnt_rt;
  logic [CW-1:0] cnt_rd;
  logic          raw_rs;
  logic          raw_rt;
  logic          waw;
  logic          struct_haz;
  logic          stall;
  logic          issue;
  logic          record_wr;

  // Clamp the requested latency and form the value loaded into the counter.
  // L+1 always fits in CW bits because CW covers MAX_LAT+1.
  always_comb begin
    lat_eff = lat_d;
    if (lat_d > LW'(MAX_LAT)) lat_eff = LW'(MAX_LAT);
    lat_ld = CW'(lat_eff) + CW'(1);
  end

  // Hazard detection on counters registered at the start of the cycle; an
  // instruction issuing this cycle is deliberately not visible here.
  always_comb begin
    cnt_rs = cnt[rs_d];
    cnt_rt = cnt[rt_d];
    cnt_rd = cnt[rd_d];
    // A D-stage branch needs its operand one cycle earlier than an E
    // consumer, so cnt = 1 (forwardable to E only) still stalls it.
    raw_rs = use_rs_d && (rs_d != '0) &&
             ((cnt_rs > CW'(1)) || (branch_d && (cnt_rs != '0)));
    raw_rt = use_rt_d && (rt_d != '0) &&
             ((cnt_rt > CW'(1)) || (branch_d && (cnt_rt != '0)));
    // The new write must not complete before an older in-flight write.
    waw = we_d && (rd_d != '0) && (cnt_rd > lat_ld);
    // The long unit is not pipelined: one operation at a time.
    struct_haz = long_d && (ubusy != '0);
    stall      = valid_d && (raw_rs || raw_rt || waw || struct_haz);
    issue      = valid_d && !stall;
    record_wr  = issue && we_d && (rd_d != '0);
  end

  // Pipeline control outputs; a redirect is held off while D is stalled so
  // the stalled branch is not lost.
  always_comb begin
    stall_f = stall;
    stall_d = stall;
    flush_e = stall;
    flush_d = (pc_src_d || jump_d) && !stall;
  end

  // Scoreboard update: clear wins over everything, including the write of
  // an instruction issuing in the same cycle; a fresh write overrides the
  // decrement of its own destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      ubusy <= '0;
    end else if (clear) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      ubusy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (r == 0) begin
          cnt[r] <= '0;
        end else if (record_wr && (rd_d == AW'(r))) begin
          cnt[r] <= lat_ld;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
      if (issue && long_d) begin
        ubusy <= lat_eff;
      end else if (ubusy != '0) begin
        ubusy <= ubusy - LW'(1);
      end
    end
  end

  // Debug view of which registers still have an outstanding write.
  always_comb begin
    pend_mask = '0;
    for (int r = 0; r < NREGS; r++) pend_mask[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit. The driver applies one vector
// per cycle just after the rising edge and pushes the hand-computed response
// into exp_q; an independent monitor pops and compares on the falling edge.
module tb_scoreboard_hazard_unit;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int LW    = 4;
  localparam int W     = 4 + NREGS;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic             valid_d;
  logic [AW-1:0]    rs_d;
  logic [AW-1:0]    rt_d;
  logic             use_rs_d;
  logic             use_rt_d;
  logic             branch_d;
  logic [AW-1:0]    rd_d;
  logic             we_d;
  logic [LW-1:0]    lat_d;
  logic             long_d;
  logic             pc_src_d;
  logic             jump_d;
  logic             clear;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [NREGS-1:0] pend_mask;

  scoreboard_hazard_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_d   (valid_d),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .use_rs_d  (use_rs_d),
    .use_rt_d  (use_rt_d),
    .branch_d  (branch_d),
    .rd_d      (rd_d),
    .we_d      (we_d),
    .lat_d     (lat_d),
    .long_d    (long_d),
    .pc_src_d  (pc_src_d),
    .jump_d    (jump_d),
    .clear     (clear),
    .stall_f   (stall_f),
    .stall_d   (stall_d),
    .flush_d   (flush_d),
    .flush_e   (flush_e),
    .pend_mask (pend_mask)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic logic [NREGS-1:0] b(input int n);
    logic [NREGS-1:0] one;
    one = 1;
    return one << n;
  endfunction

  // Expected word layout: {stall_f, stall_d, flush_d, flush_e, pend_mask}
  function automatic logic [W-1:0] pack_exp(input logic s, input logic fd,
                                            input logic [NREGS-1:0] p);
    return {s, s, fd, s, p};
  endfunction

  // Monitor: compares every cycle for which a vector was applied.
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act   = {stall_f, stall_d, flush_d, flush_e, pend_mask};
        n_checks++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL %s: got sf/sd/fd/fe=%b%b%b%b pend=%h, want %b%b%b%b pend=%h",
                   nm, act[W-1], act[W-2], act[W-3], act[W-4], act[NREGS-1:0],
                   exp_v[W-1], exp_v[W-2], exp_v[W-3], exp_v[W-4], exp_v[NREGS-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    valid_d = 0; rs_d = '0; rt_d = '0; use_rs_d = 0; use_rt_d = 0;
    branch_d = 0; rd_d = '0; we_d = 0; lat_d = '0; long_d = 0;
    pc_src_d = 0; jump_d = 0; clear = 0;
  endtask

  task automatic vec(input string nm, input logic v,
                     input int rs, input logic urs, input int rt, input logic urt,
                     input logic br, input int rd, input logic we, input int lat,
                     input logic lng, input logic pcs, input logic jmp, input logic clr,
                     input logic e_stall, input logic e_fd, input logic [NREGS-1:0] e_pend);
    @(posedge clk);
    #1;
    valid_d = v; rs_d = AW'(rs); use_rs_d = urs; rt_d = AW'(rt); use_rt_d = urt;
    branch_d = br; rd_d = AW'(rd); we_d = we; lat_d = LW'(lat); long_d = lng;
    pc_src_d = pcs; jump_d = jmp; clear = clr;
    exp_q.push_back(pack_exp(e_stall, e_fd, e_pend));
    name_q.push_back(nm);
  endtask

  // Ordinary (non-control) instruction in D.
  task automatic op(input string nm, input int rs, input logic urs, input int rt,
                    input logic urt, input int rd, input logic we, input int lat,
                    input logic lng, input logic e_stall, input logic [NREGS-1:0] e_pend);
    vec(nm, 1, rs, urs, rt, urt, 0, rd, we, lat, lng, 0, 0, 0, e_stall, 0, e_pend);
  endtask

  task automatic idle(input string nm, input logic [NREGS-1:0] e_pend);
    vec(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_pend);
  endtask

  // Pulse rst_n low mid-cycle and expect state gone before any clock edge.
  task automatic async_reset_check(input string nm);
    @(posedge clk);
    #1;
    drive_idle();
    #1;
    rst_n = 0;
    exp_q.push_back(pack_exp(0, 0, '0));
    name_q.push_back(nm);
    @(negedge clk);
    #1;
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1;

    idle("reset", '0);

    // Back-to-back ALU: no stall, cnt[3] = 1 then 0
    op("alu_prod",     1, 1, 2, 1, 3, 1, 0, 0, 0, '0);
    op("alu_cons",     3, 1, 3, 1, 4, 1, 0, 0, 0, b(3));
    idle("alu_idle1",  b(4));
    idle("alu_idle2",  '0);

    // Load-use: one stall for an E consumer
    op("ld_prod",      0, 0, 0, 0, 5, 1, 1, 0, 0, '0);
    op("ld_use_stall", 5, 1, 0, 0, 6, 1, 0, 0, 1, b(5));
    op("ld_use_go",    5, 1, 0, 0, 6, 1, 0, 0, 0, b(5));
    idle("ld_idle",    b(6));

    // Load then taken branch on it: two stalls, redirect held until issue
    op("ld_prod2",     0, 0, 0, 0, 5, 1, 1, 0, 0, '0);
    vec("br_stall1", 1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, b(5));
    vec("br_stall2", 1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, b(5));
    vec("br_go",     1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, '0);

    // Long unit busy: second long op waits for ubusy (3,2,1) to drain
    op("mul_a",        0, 0, 0, 0, 8, 1, 4, 1, 0, '0);
    op("alu_mid",      1, 1, 2, 1, 11, 1, 0, 0, 0, b(8));
    op("div_s1",       0, 0, 0, 0, 10, 1, 2, 1, 1, b(8) | b(11));
    op("div_s2",       0, 0, 0, 0, 10, 1, 2, 1, 1, b(8));
    op("div_s3",       0, 0, 0, 0, 10, 1, 2, 1, 1, b(8));
    op("div_go",       0, 0, 0, 0, 10, 1, 2, 1, 0, b(8));
    idle("div_idle1",  b(10));
    idle("div_idle2",  b(10));
    idle("div_idle3",  b(10));

    // Consumer of a latency-4 mul: exactly 4 stalls
    op("mul_b",        0, 0, 0, 0, 8, 1, 4, 1, 0, '0);
    for (int i = 1; i <= 4; i++)
      op($sformatf("mul_use_s%0d", i), 8, 1, 0, 0, 12, 1, 0, 0, 1, b(8));
    op("mul_use_go",   8, 1, 0, 0, 12, 1, 0, 0, 0, b(8));
    idle("mul_idle",   b(12));

    // Latency above MAX_LAT clamps to 8 (cnt = 9), seen through a WAW check
    op("clamp_prod",   0, 0, 0, 0, 13, 1, 15, 0, 0, '0);
    op("clamp_waw_s",  0, 0, 0, 0, 13, 1, 7, 0, 1, b(13));
    op("clamp_waw_go", 0, 0, 0, 0, 13, 1, 7, 0, 0, b(13));

    // Clear with cnt[5] = 3 and an issuing write to r6: everything dropped
    op("clr_prep",     0, 0, 0, 0, 5, 1, 2, 0, 0, b(13));
    vec("clr_issue", 1, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0, 0, b(13) | b(5));
    idle("clr_after",  '0);

    // WAW: older mul r9 still in flight, younger ALU write to r9 waits
    op("waw_prod",     0, 0, 0, 0, 9, 1, 4, 0, 0, '0);
    idle("waw_gap",    b(9));
    for (int i = 1; i <= 3; i++)
      op($sformatf("waw_s%0d", i), 0, 0, 0, 0, 9, 1, 0, 0, 1, b(9));
    op("waw_go",       0, 0, 0, 0, 9, 1, 0, 0, 0, b(9));
    // cnt[9] = 1 now: a D-stage branch must still wait one cycle
    vec("waw_br_s",  1, 9, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(9));
    vec("waw_br_go", 1, 9, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

    // Source equals destination: checks old cnt, then reloads it
    op("same_prod",    0, 0, 0, 0, 5, 1, 1, 0, 0, '0);
    op("same_s",       5, 1, 0, 0, 5, 1, 0, 0, 1, b(5));
    op("same_go",      5, 1, 0, 0, 5, 1, 0, 0, 0, b(5));
    idle("same_hold",  b(5));
    idle("same_idle",  '0);

    // Jump with no hazard
    vec("jump", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, '0);

    // Register 0 is never recorded and never stalls
    op("r0_prod",      0, 0, 0, 0, 0, 1, 1, 0, 0, '0);
    vec("r0_br",     1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

    // valid_d = 0: no stall and no record even with a pending source
    op("inv_prod",     0, 0, 0, 0, 7, 1, 3, 0, 0, '0);
    vec("inv_cons",  0, 7, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, b(7));
    idle("inv_idle",   b(7));

    // Asynchronous reset in the middle of a long mul
    op("rst_mul",      0, 0, 0, 0, 8, 1, 4, 1, 0, b(7));
    idle("rst_pre",    b(7) | b(8));
    async_reset_check("rst_async");
    op("rst_post",     8, 1, 0, 0, 14, 1, 0, 1, 0, '0);
    idle("rst_end",    b(14));

    // Drain: the monitor must have consumed every expectation
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
